// File: rtl/cdec8_mem_pkg.sv
// cdec8_mem_pkg: shared constants for the CDEC8 main-memory responder.
// Holds the FSM state encodings, the memory geometry and a small helper.
// The optional power-on zero sweep is selected by the macro
// CDEC8_MEM_CLEAR_EN (see cdec8_mem.sv).
package cdec8_mem_pkg;

  // Memory geometry.
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

  // FSM state encodings (plain constants so legacy code can share them).
  localparam logic [1:0] MEM_CLEAR = 2'd0;
  localparam logic [1:0] MEM_RUN   = 2'd1;
  localparam logic [1:0] MEM_LOAD  = 2'd2;

  // Debug view of the controller, exported on the top-level debug port.
  typedef struct packed {
    logic [1:0] state;
    logic       busy;
    logic       ld_ready;
  } mem_dbg_t;

endpackage

// File: rtl/cdec8_ram256.sv
// cdec8_ram256: storage array for cdec8_mem.
// One asynchronous read port (CPU side), one registered read port
// (debug readout, read-before-write) and one write port. The array itself
// is never reset; only the registered debug read data is.
module cdec8_ram256 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dbg_data_q;

  // Write port: one word per clock when we is high.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Debug read port: samples the array before any same-edge write lands.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= mem[dbg_addr];
    end
  end

  // CPU read port is purely combinational.
  assign rdata    = mem[raddr];
  assign dbg_data = dbg_data_q;

endmodule

// File: rtl/cdec8_mem.sv
// cdec8_mem: main memory responder for the CDEC8 core.
// 256x8 RAM with combinational CPU reads, clocked CPU writes, a program
// loader that holds the core in reset while a host streams bytes over a
// valid/ready handshake, and the resad/resdt debug readout.
// Optional feature: define CDEC8_MEM_CLEAR_EN to compile in a CLEAR state
// that zero-sweeps the whole array after every reset before the core runs.
//
// Loader handshake: a beat transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_data/ld_last are qualified by ld_valid only.
// ld_ready is high for the whole of LOAD and never depends on ld_valid.
// ld_valid outside LOAD is simply dropped, nothing is remembered.
module cdec8_mem
  import cdec8_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mmwr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset_N,
  output logic              busy,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  input  logic [ADDR_W-1:0] resad,
  output logic [DATA_W-1:0] resdt,
  output mem_dbg_t          dbg_o
);

`ifdef CDEC8_MEM_CLEAR_EN
  localparam logic [1:0] RESET_STATE = MEM_CLEAR;
`else
  localparam logic [1:0] RESET_STATE = MEM_RUN;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              cpu_rst_n_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Pointer at the top address: the sweep or load ends on this beat.
  logic ptr_at_top;
  assign ptr_at_top = &ptr_q;

  // Next-state, pointer/count update and write-port mux (CPU/loader/clear).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = adrs;
    ram_wdata = wr_data;
    case (state_q)
      MEM_RUN: begin
        // CPU owns the write port; a write coinciding with ld_start lands.
        ram_we = mmwr_en;
        if (ld_start) begin
          state_d = MEM_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      MEM_LOAD: begin
        // Loader owns the write port; CPU writes and ld_start are ignored.
        if (ld_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
          ram_wdata = ld_data;
          ptr_d     = ptr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
          // Full-array load ends on the wrap even without ld_last.
          if (ld_last || ptr_at_top) begin
            state_d = MEM_RUN;
          end
        end
      end
`ifdef CDEC8_MEM_CLEAR_EN
      MEM_CLEAR: begin
        // Zero sweep, one address per cycle; all CPU/loader inputs ignored.
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_at_top) begin
          state_d = MEM_RUN;
        end
      end
`endif
      default: begin
        state_d = RESET_STATE;
        ptr_d   = '0;
      end
    endcase
  end

  // Controller registers; reset aborts any load or sweep but not the RAM.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      cpu_rst_n_q <= (state_d == MEM_RUN);
    end
  end

  cdec8_ram256 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock    (clock),
    .reset_N  (reset_N),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .raddr    (adrs),
    .rdata    (rd_data),
    .dbg_addr (resad),
    .dbg_data (resdt)
  );

  assign cpu_reset_N = cpu_rst_n_q;
  assign busy        = (state_q != MEM_RUN);
  assign ld_ready    = (state_q == MEM_LOAD);
  assign ld_count    = cnt_q;

  assign dbg_o.state    = state_q;
  assign dbg_o.busy     = busy;
  assign dbg_o.ld_ready = ld_ready;

endmodule
